// File: rtl/asg_pkg.sv
// Shared definitions for the multi-target radar pulse scheduler:
// parameter defaults, sweep FSM encoding and the target-slot record.
package asg_pkg;

   localparam int SIZE_DEF    = 3200;
   localparam int NUM_TGT_DEF = 8;
   localparam int RANGE_W_DEF = 12;
   localparam int WIDTH_W_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // One target slot; field widths follow the package defaults
   typedef struct packed {
      logic                   en;
      logic [RANGE_W_DEF-1:0] rangeStart;
      logic [WIDTH_W_DEF-1:0] pulseWidth;
   } tgt_entry_t;

endpackage

// File: rtl/asg_mt_scheduler_if.sv
// Configuration and output bundle of the scheduler. The bench drives it
// through the master modport, the scheduler sits on the slave modport.
interface asg_mt_scheduler_if #(
   parameter int NUM_TGT = 8,
   parameter int RANGE_W = 12,
   parameter int WIDTH_W = 4
);
   logic                       RADAR_TRIG_PE;
   logic                       USEC_PE;
   logic                       CFG_WE;
   logic [$clog2(NUM_TGT)-1:0] CFG_ADDR;
   logic                       CFG_EN;
   logic [RANGE_W-1:0]         CFG_RANGE;
   logic [WIDTH_W-1:0]         CFG_WIDTH;
   logic                       CFG_COMMIT;
   logic                       CFG_PENDING;
   logic                       SWEEP_ACTIVE;
   logic [NUM_TGT-1:0]         TGT_HIT;
   logic                       GEN_SIGNAL;

   modport master (
      output RADAR_TRIG_PE, USEC_PE, CFG_WE, CFG_ADDR, CFG_EN,
             CFG_RANGE, CFG_WIDTH, CFG_COMMIT,
      input  CFG_PENDING, SWEEP_ACTIVE, TGT_HIT, GEN_SIGNAL
   );

   modport slave (
      input  RADAR_TRIG_PE, USEC_PE, CFG_WE, CFG_ADDR, CFG_EN,
             CFG_RANGE, CFG_WIDTH, CFG_COMMIT,
      output CFG_PENDING, SWEEP_ACTIVE, TGT_HIT, GEN_SIGNAL
   );
endinterface

// File: rtl/asg_mt_window.sv
// Per-slot range window: the slot hits while the sweep counter lies in
// [rangeStart, rangeStart+pulseWidth). The end point is one bit wider
// than the range field so a window near the top of the range never wraps.
module asg_mt_window #(
   parameter int RANGE_W = 12,
   parameter int WIDTH_W = 4,
   parameter int CNT_W   = 12
) (
   input  logic               i_active,
   input  logic               i_en,
   input  logic [RANGE_W-1:0] i_rangeStart,
   input  logic [WIDTH_W-1:0] i_pulseWidth,
   input  logic [CNT_W-1:0]   i_cnt,
   output logic               o_hit
);

   localparam int CMP_W = (CNT_W > RANGE_W + 1) ? CNT_W : RANGE_W + 1;

   logic [RANGE_W:0]   w_end;
   logic [CMP_W-1:0]   w_cnt;
   logic [CMP_W-1:0]   w_start;
   logic [CMP_W-1:0]   w_stop;

   assign w_end   = {1'b0, i_rangeStart} + (RANGE_W+1)'(i_pulseWidth);
   assign w_cnt   = CMP_W'(i_cnt);
   assign w_start = CMP_W'(i_rangeStart);
   assign w_stop  = CMP_W'(w_end);

   // Truncation at sweep end falls out naturally: the counter never
   // passes SIZE-1, so the tail of a long window is simply never reached
   assign o_hit = i_active && i_en && (i_pulseWidth != '0) &&
                  (w_cnt >= w_start) && (w_cnt < w_stop);

endmodule

// File: rtl/asg_mt_scheduler.sv
// Multi-target pulse scheduler. A trigger starts a sweep counted in
// microsecond ticks; each enabled slot raises its hit line while the count
// sits inside its window. Configuration goes into a shadow table and is
// copied to the active table only on a trigger, so a running sweep is
// never disturbed by reconfiguration.
module asg_mt_scheduler
   import asg_pkg::*;
#(
   parameter int SIZE    = SIZE_DEF,
   parameter int NUM_TGT = NUM_TGT_DEF,
   parameter int RANGE_W = RANGE_W_DEF,
   parameter int WIDTH_W = WIDTH_W_DEF
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RESETN,
   asg_mt_scheduler_if.slave bus
);

   localparam int               CNT_W = $clog2(SIZE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SIZE - 1);

   state_t             r_state;
   state_t             w_stateNext;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cntNext;
   logic               w_sweepActive;
   logic               r_pending;
   tgt_entry_t         r_shadow [NUM_TGT];
   tgt_entry_t         r_active [NUM_TGT];
   logic [NUM_TGT-1:0] w_hit;
   logic [NUM_TGT-1:0] r_hit;
   logic               r_gen;
   logic               w_applyCommit;

   assign w_applyCommit = bus.RADAR_TRIG_PE && r_pending;

   // Sweep state and tick counter register
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   // Next state: a trigger always (re)starts the sweep, even on a tick
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      if (bus.RADAR_TRIG_PE) begin
         w_stateNext = SWEEP;
         w_cntNext   = '0;
      end else if (r_state == SWEEP && bus.USEC_PE) begin
         if (r_cnt == LAST) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end else begin
            w_cntNext = r_cnt + 1'b1;
         end
      end
   end

   // FSM outputs
   always_comb begin
      w_sweepActive = (r_state == SWEEP);
   end

   // Commit flag: armed by a commit, consumed by the next trigger
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         r_pending <= 1'b0;
      end else if (w_applyCommit) begin
         r_pending <= 1'b0;
      end else if (bus.CFG_COMMIT) begin
         r_pending <= 1'b1;
      end
   end

   // Shadow writes and shadow-to-active copy; a same-cycle write and copy
   // both land, the copy taking the shadow contents from before the write
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         for (int i = 0; i < NUM_TGT; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (bus.CFG_WE) begin
            r_shadow[bus.CFG_ADDR] <= '{en:         bus.CFG_EN,
                                        rangeStart: bus.CFG_RANGE,
                                        pulseWidth: bus.CFG_WIDTH};
         end
         if (w_applyCommit) begin
            r_active <= r_shadow;
         end
      end
   end

   for (genvar g = 0; g < NUM_TGT; g++) begin : gWin
      asg_mt_window #(
         .RANGE_W (RANGE_W),
         .WIDTH_W (WIDTH_W),
         .CNT_W   (CNT_W)
      ) u_window (
         .i_active     (w_sweepActive),
         .i_en         (r_active[g].en),
         .i_rangeStart (r_active[g].rangeStart),
         .i_pulseWidth (r_active[g].pulseWidth),
         .i_cnt        (r_cnt),
         .o_hit        (w_hit[g])
      );
   end

   // Registered hit outputs, one cycle behind the counter
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         r_hit <= '0;
         r_gen <= 1'b0;
      end else begin
         r_hit <= w_hit;
         r_gen <= |w_hit;
      end
   end

   assign bus.CFG_PENDING  = r_pending;
   assign bus.SWEEP_ACTIVE = w_sweepActive;
   assign bus.TGT_HIT      = r_hit;
   assign bus.GEN_SIGNAL   = r_gen;

endmodule

// File: tb/tb_asg_mt_scheduler.sv
// Bench for the multi-target scheduler. A behavioural model steps alongside
// the DUT each cycle and pushes the outputs expected after the next clock
// edge into a scoreboard; they are popped and compared half a cycle later.
// Directed scenarios add pulse-length totals measured on the DUT outputs.
module tb_asg_mt_scheduler;

   localparam int SIZE    = 3200;
   localparam int NUM_TGT = 8;

   typedef struct {
      logic [NUM_TGT-1:0] hit;
      logic               sweep;
      logic               pend;
   } expect_t;

   logic clk;
   logic rstN;

   asg_mt_scheduler_if #(.NUM_TGT(NUM_TGT), .RANGE_W(12), .WIDTH_W(4)) bus ();

   asg_mt_scheduler #(
      .SIZE(SIZE), .NUM_TGT(NUM_TGT), .RANGE_W(12), .WIDTH_W(4)
   ) dut (
      .SYS_CLK    (clk),
      .SYS_RESETN (rstN),
      .bus        (bus)
   );

   int      vectorCount = 0;
   int      missCount   = 0;
   int      genCount    = 0;
   int      slotCount [NUM_TGT];
   expect_t sbQueue [$];

   int mState, mCnt, mPend;
   int shEn [NUM_TGT], shRng [NUM_TGT], shWid [NUM_TGT];
   int acEn [NUM_TGT], acRng [NUM_TGT], acWid [NUM_TGT];

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: count it and report a miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Pop the expectation for the edge just passed and compare all outputs
   task automatic compareScoreboard();
      expect_t e;
      if (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         checkOutput("TGT_HIT", 32'(bus.TGT_HIT), 32'(e.hit));
         checkOutput("GEN_SIGNAL", 32'(bus.GEN_SIGNAL), 32'(|e.hit));
         checkOutput("SWEEP_ACTIVE", 32'(bus.SWEEP_ACTIVE), 32'(e.sweep));
         checkOutput("CFG_PENDING", 32'(bus.CFG_PENDING), 32'(e.pend));
         if (bus.GEN_SIGNAL === 1'b1) genCount++;
         for (int i = 0; i < NUM_TGT; i++)
            if (bus.TGT_HIT[i] === 1'b1) slotCount[i]++;
      end
   endtask

   task automatic clearStats();
      genCount = 0;
      for (int i = 0; i < NUM_TGT; i++) slotCount[i] = 0;
   endtask

   task automatic resetModel();
      mState = 0; mCnt = 0; mPend = 0;
      for (int i = 0; i < NUM_TGT; i++) begin
         shEn[i] = 0; shRng[i] = 0; shWid[i] = 0;
         acEn[i] = 0; acRng[i] = 0; acWid[i] = 0;
      end
   endtask

   // One clock of stimulus; the model predicts the post-edge outputs
   task automatic applyStimulus(input bit trig, input bit usec, input bit we,
                                input int addr, input int en, input int rng,
                                input int wid, input bit commit);
      expect_t e;
      int      newPend;
      @(negedge clk);
      compareScoreboard();
      bus.RADAR_TRIG_PE = trig;
      bus.USEC_PE       = usec;
      bus.CFG_WE        = we;
      bus.CFG_ADDR      = 3'(addr);
      bus.CFG_EN        = 1'(en);
      bus.CFG_RANGE     = 12'(rng);
      bus.CFG_WIDTH     = 4'(wid);
      bus.CFG_COMMIT    = commit;
      e.hit = '0;
      for (int i = 0; i < NUM_TGT; i++)
         if (mState == 1 && acEn[i] == 1 && acWid[i] != 0 &&
             mCnt >= acRng[i] && mCnt < acRng[i] + acWid[i])
            e.hit[i] = 1'b1;
      newPend = (trig && mPend == 1) ? 0 : (commit ? 1 : mPend);
      if (trig && mPend == 1)
         for (int i = 0; i < NUM_TGT; i++) begin
            acEn[i] = shEn[i]; acRng[i] = shRng[i]; acWid[i] = shWid[i];
         end
      if (we) begin
         shEn[addr] = en; shRng[addr] = rng; shWid[addr] = wid;
      end
      if (trig) begin
         mState = 1; mCnt = 0;
      end else if (mState == 1 && usec) begin
         if (mCnt == SIZE - 1) begin
            mState = 0; mCnt = 0;
         end else begin
            mCnt++;
         end
      end
      mPend   = newPend;
      e.sweep = (mState == 1);
      e.pend  = (mPend == 1);
      sbQueue.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic runTicks(input int n);
      repeat (n) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic writeSlot(input int addr, input int en, input int rng, input int wid);
      applyStimulus(0, 0, 1, addr, en, rng, wid, 0);
   endtask

   task automatic commitCfg();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic trigger();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Assert reset away from the clock edge and check outputs drop at once
   task automatic resetNow();
      rstN = 1'b0;
      #1;
      checkOutput("RST_GEN", 32'(bus.GEN_SIGNAL), 32'd0);
      checkOutput("RST_HIT", 32'(bus.TGT_HIT), 32'd0);
      checkOutput("RST_SWEEP", 32'(bus.SWEEP_ACTIVE), 32'd0);
      checkOutput("RST_PEND", 32'(bus.CFG_PENDING), 32'd0);
      sbQueue.delete();
      resetModel();
      bus.RADAR_TRIG_PE = 1'b0; bus.USEC_PE = 1'b0; bus.CFG_WE = 1'b0;
      bus.CFG_COMMIT = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("RST_HOLD_GEN", 32'(bus.GEN_SIGNAL), 32'd0);
      rstN = 1'b1;
   endtask

   // Directed scenarios
   initial begin
      rstN = 1'b0;
      bus.RADAR_TRIG_PE = 1'b0; bus.USEC_PE = 1'b0; bus.CFG_WE = 1'b0;
      bus.CFG_ADDR = '0; bus.CFG_EN = 1'b0; bus.CFG_RANGE = '0;
      bus.CFG_WIDTH = '0; bus.CFG_COMMIT = 1'b0;
      resetModel();
      clearStats();
      #2;
      resetNow();

      // Eight evenly spaced 3-tick pulses; repeated commit is harmless
      for (int i = 0; i < NUM_TGT; i++) writeSlot(i, 1, 300 + 400 * i, 3);
      commitCfg();
      commitCfg();
      idle(2);
      clearStats();
      trigger();
      runTicks(SIZE);
      idle(4);
      checkOutput("S1_GEN_CYCLES", 32'(genCount), 32'd48);

      // Pulse running off the sweep end is cut at CNT 3199
      writeSlot(0, 1, 3198, 5);
      for (int i = 1; i < NUM_TGT; i++) writeSlot(i, 0, 0, 0);
      commitCfg();
      idle(1);
      clearStats();
      trigger();
      runTicks(SIZE);
      idle(6);
      checkOutput("S2_GEN_CYCLES", 32'(genCount), 32'd4);

      // Mid-sweep reconfiguration only applies from the next trigger
      clearStats();
      trigger();
      runTicks(500);
      writeSlot(2, 1, 2000, 2);
      commitCfg();
      runTicks(SIZE - 500);
      idle(2);
      checkOutput("S3_OLD_PATTERN", 32'(genCount), 32'd4);

      // New pattern, then a restart on a trigger coinciding with a tick
      clearStats();
      trigger();
      runTicks(1000);
      checkOutput("S4_BEFORE_RESTART", 32'(genCount), 32'd0);
      clearStats();
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
      runTicks(SIZE);
      idle(2);
      checkOutput("S4_NEW_PATTERN", 32'(genCount), 32'd8);

      // Overlapping slots and a zero-width slot
      writeSlot(0, 0, 0, 0);
      writeSlot(2, 0, 0, 0);
      writeSlot(1, 1, 50, 4);
      writeSlot(4, 1, 52, 4);
      writeSlot(3, 1, 60, 0);
      commitCfg();
      idle(1);
      clearStats();
      trigger();
      runTicks(SIZE);
      idle(2);
      checkOutput("S5_GEN_CYCLES", 32'(genCount), 32'd12);
      checkOutput("S5_SLOT1", 32'(slotCount[1]), 32'd8);
      checkOutput("S5_SLOT4", 32'(slotCount[4]), 32'd8);
      checkOutput("S5_SLOT3_W0", 32'(slotCount[3]), 32'd0);

      // Reset in the middle of a pulse
      writeSlot(1, 0, 0, 0);
      writeSlot(4, 0, 0, 0);
      writeSlot(3, 0, 0, 0);
      writeSlot(0, 1, 300, 3);
      commitCfg();
      idle(1);
      trigger();
      runTicks(301);
      @(negedge clk);
      compareScoreboard();
      checkOutput("S6_GEN_BEFORE_RST", 32'(bus.GEN_SIGNAL), 32'd1);
      resetNow();
      clearStats();
      trigger();
      runTicks(400);
      checkOutput("S6_CLEARED_TABLE", 32'(genCount), 32'd0);
      writeSlot(0, 1, 300, 3);
      commitCfg();
      idle(1);
      clearStats();
      trigger();
      runTicks(SIZE);
      idle(2);
      checkOutput("S6_RECONFIG", 32'(genCount), 32'd6);

      @(negedge clk);
      compareScoreboard();
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/asg_mt_scheduler.md
ASG_MT_SCHEDULER -- requirements
Module: asg_mt_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): SIZE, 3200, sweep length in USEC_PE ticks; NUM_TGT, 8, number of target slots; RANGE_W, 12, range field width; WIDTH_W, 4, pulse-width field width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), with clock and reset first:
- SYS_CLK, in, 1, system clock (100 MHz).
- SYS_RESETN, in, 1, reset; asynchronous, active-low.
- RADAR_TRIG_PE, in, 1, single-cycle sweep start.
- USEC_PE, in, 1, single-cycle microsecond tick.
- CFG_WE, in, 1, shadow-table write strobe.
- CFG_ADDR, in, clog2(NUM_TGT), target slot select.
- CFG_EN, in, 1, slot enable.
- CFG_RANGE, in, RANGE_W, pulse start in ticks.
- CFG_WIDTH, in, WIDTH_W, pulse length in ticks.
- CFG_COMMIT, in, 1, arm copy of shadow table into active table.
- CFG_PENDING, out, 1, commit armed and not yet applied.
- SWEEP_ACTIVE, out, 1, sweep in progress.
- TGT_HIT, out, NUM_TGT, per-slot pulse active.
- GEN_SIGNAL, out, 1, OR of TGT_HIT.

Function
REQ-003 The block SHALL hold two tables of NUM_TGT entries {EN, RANGE, WIDTH}: a shadow table and an active table.
REQ-004 A CFG_WE cycle SHALL write the shadow entry CFG_ADDR; the write SHALL be visible to a commit taken in the next cycle.
REQ-005 CFG_COMMIT SHALL set CFG_PENDING the following cycle; a repeated CFG_COMMIT while pending SHALL have no further effect.
REQ-006 On RADAR_TRIG_PE with CFG_PENDING=1, the block SHALL copy the whole shadow table into the active table in that cycle and clear CFG_PENDING.
REQ-007 A CFG_WE and a commit-on-trigger in the same cycle SHALL both take effect, the copy using the pre-write shadow value.
REQ-008 The FSM SHALL have two states: IDLE and SWEEP.
- IDLE -> SWEEP on RADAR_TRIG_PE, with CNT<=0.
- SWEEP, USEC_PE with CNT<SIZE-1: CNT<=CNT+1.
- SWEEP, USEC_PE with CNT=SIZE-1: -> IDLE, CNT<=0.
REQ-009 RADAR_TRIG_PE in SWEEP SHALL restart the sweep (CNT<=0, stay in SWEEP). When RADAR_TRIG_PE and USEC_PE coincide, the trigger SHALL win.
REQ-010 CNT SHALL be clog2(SIZE) bits wide and SHALL never exceed SIZE-1.
REQ-011 SWEEP_ACTIVE SHALL be 1 exactly while in SWEEP.
REQ-012 Slot i SHALL be hit when all of the following hold: state is SWEEP; EN_i=1; WIDTH_i!=0; RANGE_i <= CNT < RANGE_i+WIDTH_i. The sum SHALL be computed RANGE_W+1 bits wide, with no wrap.
REQ-013 TGT_HIT and GEN_SIGNAL SHALL be registered, reflecting the CNT/state of the previous SYS_CLK (one-cycle latency).
REQ-014 A pulse extending past SIZE-1 SHALL be truncated at sweep end, and a RANGE >= SIZE SHALL never hit.
REQ-015 Overlapping slots SHALL OR together in GEN_SIGNAL while remaining individually visible on TGT_HIT.
REQ-016 USEC_PE in IDLE SHALL be ignored.

Reset
REQ-017 Assertion of SYS_RESETN=0 SHALL immediately force the following, regardless of SYS_CLK: state IDLE, CNT=0, CFG_PENDING=0, SWEEP_ACTIVE=0, TGT_HIT=0, GEN_SIGNAL=0, and both tables all-zero (all slots disabled).
REQ-018 Reset asserted mid-sweep SHALL drop GEN_SIGNAL in the same instant. After deassertion, the block SHALL wait for a fresh RADAR_TRIG_PE.

Structure
REQ-019 The defaults for SIZE, NUM_TGT, RANGE_W and WIDTH_W, the FSM state encoding, and the target-entry record type SHALL live in shared package asg_pkg.
REQ-020 The per-slot range-window compare (REQ-012) SHALL be sub-module asg_mt_window, instantiated NUM_TGT times by generate.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Slots 0..7 = {EN=1, RANGE=300+400*i, WIDTH=3}, commit, trigger, 3200 ticks -> GEN_SIGNAL high exactly at CNT 300-302, 700-702, ..., 3100-3102; SWEEP_ACTIVE falls after tick 3199.
- Slot 0 = {1, 3198, 5} -> hit at CNT 3198-3199 only; no hit after the return to IDLE.
- Rewrite slot 2 and commit mid-sweep -> the current sweep keeps the old pattern, the next trigger uses the new pattern, and CFG_PENDING falls on that trigger.
- Trigger coincident with USEC_PE at CNT=1000 -> CNT=0 the next cycle and the sweep restarts.
- Slots 1 = {1, 50, 4} and 4 = {1, 52, 4} -> TGT_HIT[1] at CNT 50-53, TGT_HIT[4] at CNT 52-55, GEN_SIGNAL at CNT 50-55; WIDTH=0 slot never hits.
- SYS_RESETN pulsed low at CNT=301 during a pulse -> GEN_SIGNAL is 0 immediately; state IDLE and tables cleared; no output until re-configuration and trigger.
